erasable_ram_sequencer: RTL and testbench

ERASABLE_RAM_SEQUENCER -- requirements
Module: erasable_ram_sequencer

---
 rtl/erasable_ram_sequencer.sv | 148 ++++++++++++++
 tb/tb_erasable_ram_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/erasable_ram_sequencer.sv
// Two-requester round-robin sequencer driving an asynchronous SRAM through
// IDLE/SETUP/ACCESS/END phases with fully registered strobes and data.
module erasable_ram_sequencer #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [10:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_be,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [10:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic        b_ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        E_,
  output logic        G_,
  output logic        W_,
  output logic        UB_,
  output logic        LB_,
  output logic [10:0] A,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [15:0] dq_in
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StEnd} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic        sel_b;
  logic        we_l;
  logic [1:0]  be_l;
  logic        last_b;
  logic        a_blank;
  logic        b_blank;

  logic        a_elig;
  logic        b_elig;
  logic        grant_a;
  logic        g_we;
  logic [10:0] g_addr;
  logic [15:0] g_wdata;
  logic [1:0]  g_be;

  // A requester is blanked for the IDLE cycle right after its own ack.
  always_comb begin
    a_elig  = a_req & ~a_blank;
    b_elig  = b_req & ~b_blank;
    grant_a = a_elig & (~b_elig | last_b);
    g_we    = grant_a ? a_we    : b_we;
    g_addr  = grant_a ? a_addr  : b_addr;
    g_wdata = grant_a ? a_wdata : b_wdata;
    g_be    = grant_a ? a_be    : b_be;
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state   <= StIdle;
      cnt     <= 4'd0;
      sel_b   <= 1'b0;
      we_l    <= 1'b0;
      be_l    <= 2'b00;
      last_b  <= 1'b1;
      a_blank <= 1'b0;
      b_blank <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      rdata   <= 16'd0;
      busy    <= 1'b0;
      E_      <= 1'b1;
      G_      <= 1'b1;
      W_      <= 1'b1;
      UB_     <= 1'b1;
      LB_     <= 1'b1;
      A       <= 11'd0;
      dq_out  <= 16'd0;
      dq_oe   <= 1'b0;
    end else begin
      a_blank <= a_ack;
      b_blank <= b_ack;
      unique case (state)
        StIdle: begin
          if (a_elig || b_elig) begin
            state  <= StSetup;
            busy   <= 1'b1;
            sel_b  <= ~grant_a;
            last_b <= ~grant_a;
            we_l   <= g_we;
            be_l   <= g_be;
            A      <= g_addr;
            E_     <= 1'b0;
            G_     <= 1'b1;
            W_     <= 1'b1;
            if (g_we) begin
              dq_oe  <= 1'b1;
              dq_out <= g_wdata;
              UB_    <= ~g_be[1];
              LB_    <= ~g_be[0];
            end else begin
              dq_oe  <= 1'b0;
              UB_    <= 1'b0;
              LB_    <= 1'b0;
            end
          end
        end
        StSetup: begin
          state <= StAccess;
          cnt   <= 4'd0;
          // A write with no byte enabled never pulses W_.
          if (we_l) W_ <= ~(|be_l);
          else      G_ <= 1'b0;
        end
        StAccess: begin
          if (cnt == 4'(WAIT_CYC - 1)) begin
            state <= StEnd;
            cnt   <= 4'd0;
            G_    <= 1'b1;
            W_    <= 1'b1;
            if (!we_l) rdata <= dq_in;
            if (sel_b) b_ack <= 1'b1;
            else       a_ack <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        StEnd: begin
          state <= StIdle;
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          E_    <= 1'b1;
          dq_oe <= 1'b0;
          UB_   <= 1'b1;
          LB_   <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_erasable_ram_sequencer.sv
// Bench for erasable_ram_sequencer: directed vector table, arbitration and reset
// corner cases, then random two-requester traffic against a shadow memory.
module tb_erasable_ram_sequencer;
  localparam int unsigned WAIT_CYC = 2;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [10:0] a_addr, b_addr, A;
  logic [15:0] a_wdata, b_wdata, rdata, dq_out, dq_in;
  logic [1:0]  a_be, b_be;
  logic        busy, E_, G_, W_, UB_, LB_, dq_oe;

  erasable_ram_sequencer #(.WAIT_CYC(WAIT_CYC)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack),
    .rdata(rdata), .busy(busy), .E_(E_), .G_(G_), .W_(W_), .UB_(UB_), .LB_(LB_),
    .A(A), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  // SRAM model: reads float to a marker value when not enabled.
  logic [15:0] sram [2048];
  logic [15:0] ref_mem [2048];
  bit          sram_init = 1'b0;
  assign dq_in = (!E_ && !G_) ? sram[A] : 16'hDEAD;

  always @(posedge SIM_CLK) begin
    if (!sram_init) begin
      for (int i = 0; i < 2048; i++) sram[i] = 16'o40000;
      sram_init = 1'b1;
    end else if (!E_ && !W_) begin
      if (!UB_) sram[A][15:8] = dq_out[15:8];
      if (!LB_) sram[A][7:0]  = dq_out[7:0];
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  // Bus-safety invariants, every cycle once out of the initial reset.
  always @(negedge SIM_CLK) begin
    if (chk_en) begin
      check("invariant", {31'd0, !(!G_ && !W_) && !((!G_ || !W_) && E_) && !(dq_oe && !G_)},
            32'd1);
    end
  end

  typedef struct {
    bit          is_b;
    bit          we;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    int          exp_glow;
    int          exp_wlow;
  } vec_t;

  vec_t vecs[9];

  task automatic do_txn(input vec_t v, input int idx);
    int t = 0, glow = 0, wlow = 0, oe_bad = 0, addr_bad = 0;
    bit got = 1'b0;
    repeat (2) @(posedge SIM_CLK);
    #1;
    check($sformatf("v%0d idle", idx), {31'd0, busy}, 32'd0);
    if (v.is_b) begin
      b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_be = v.be; b_req = 1'b1;
    end else begin
      a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_be = v.be; a_req = 1'b1;
    end
    while (!got && t < 20) begin
      @(posedge SIM_CLK);
      #1;
      t++;
      if (!G_) glow++;
      if (!W_) begin
        wlow++;
        if (!dq_oe) oe_bad++;
      end
      if (!E_ && A !== v.addr) addr_bad++;
      if (a_ack || b_ack) got = 1'b1;
    end
    check($sformatf("v%0d latency", idx), t, 2 + WAIT_CYC);
    check($sformatf("v%0d ack side", idx), {30'd0, a_ack, b_ack}, v.is_b ? 32'd1 : 32'd2);
    check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    check($sformatf("v%0d G_ low cycles", idx), glow, v.exp_glow);
    check($sformatf("v%0d W_ low cycles", idx), wlow, v.exp_wlow);
    check($sformatf("v%0d oe/addr", idx), oe_bad + addr_bad, 0);
    a_req = 1'b0;
    b_req = 1'b0;
    if (v.we) ref_mem[v.addr] = merge(ref_mem[v.addr], v.wdata, v.be);
  endtask

  initial begin
    int acks, last_t, t, a_age, b_age;
    bit a_pend, b_pend;

    for (int i = 0; i < 2048; i++) ref_mem[i] = 16'o40000;
    SIM_RST = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    repeat (3) @(posedge SIM_CLK);
    #1;
    check("reset strobes", {27'd0, E_, G_, W_, UB_, LB_}, 32'h1F);
    check("reset dq", {15'd0, dq_oe, dq_out}, 32'd0);
    check("reset A", A, 0);
    check("reset rdata", rdata, 0);
    check("reset ack/busy", {29'd0, a_ack, b_ack, busy}, 0);
    SIM_RST = 1'b0;
    chk_en  = 1'b1;

    vecs[0] = '{0, 0, 11'o0,    16'h0,    2'b00, 16'o40000, WAIT_CYC, 0};
    vecs[1] = '{0, 1, 11'o1777, 16'o12345, 2'b11, 16'o40000, 0, WAIT_CYC};
    vecs[2] = '{1, 0, 11'o1777, 16'h0,    2'b00, 16'o12345, WAIT_CYC, 0};
    vecs[3] = '{0, 1, 11'o5,    16'o77777, 2'b00, 16'o12345, 0, 0};
    vecs[4] = '{0, 0, 11'o5,    16'h0,    2'b00, 16'o40000, WAIT_CYC, 0};
    vecs[5] = '{1, 1, 11'o7,    16'hABCD, 2'b01, 16'o40000, 0, WAIT_CYC};
    vecs[6] = '{0, 0, 11'o7,    16'h0,    2'b00, 16'h40CD,  WAIT_CYC, 0};
    vecs[7] = '{1, 1, 11'o7,    16'h1234, 2'b10, 16'h40CD,  0, WAIT_CYC};
    vecs[8] = '{1, 0, 11'o7,    16'h0,    2'b00, 16'h12CD,  WAIT_CYC, 0};
    for (int i = 0; i < 9; i++) do_txn(vecs[i], i);

    // Both requesters held: last grant was B, so A leads and grants alternate.
    repeat (2) @(posedge SIM_CLK);
    #1;
    a_we = 0; a_addr = 11'o0;    a_req = 1'b1;
    b_we = 0; b_addr = 11'o1777; b_req = 1'b1;
    acks = 0; last_t = 0; t = 0;
    while (acks < 4 && t < 60) begin
      @(posedge SIM_CLK);
      #1;
      t++;
      if (a_ack || b_ack) begin
        check($sformatf("rr ack%0d side", acks), {30'd0, a_ack, b_ack},
              (acks % 2 == 0) ? 32'd2 : 32'd1);
        check($sformatf("rr ack%0d rdata", acks), rdata,
              (acks % 2 == 0) ? 16'o40000 : 16'o12345);
        if (acks > 0) check($sformatf("rr ack%0d spacing", acks), t - last_t, 3 + WAIT_CYC);
        last_t = t;
        acks++;
      end
    end
    check("rr ack count", acks, 4);
    a_req = 1'b0;
    b_req = 1'b0;

    // Reset during the second ACCESS cycle of a write, with B requesting alongside.
    repeat (2) @(posedge SIM_CLK);
    #1;
    a_we = 1; a_addr = 11'o100; a_wdata = 16'o40000; a_be = 2'b11; a_req = 1'b1;
    repeat (3) @(posedge SIM_CLK);
    #1;
    check("abort W_ low before reset", {31'd0, W_}, 0);
    SIM_RST = 1'b1; a_req = 1'b0;
    b_we = 0; b_addr = 11'o0; b_req = 1'b1;
    @(posedge SIM_CLK);
    #1;
    check("abort strobes", {28'd0, E_, G_, W_, dq_oe}, 32'hE);
    check("abort ack/busy", {29'd0, a_ack, b_ack, busy}, 0);
    SIM_RST = 1'b0; b_req = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge SIM_CLK);
      #1;
      if (a_ack || b_ack || busy || !E_) acks++;
    end
    check("abort bus idle", acks, 0);

    // Random traffic on a small address window; reads scored against ref_mem.
    a_pend = 0; b_pend = 0; a_age = 0; b_age = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge SIM_CLK);
      #1;
      if (a_ack) begin
        check("rnd a ack pending", {31'd0, a_pend}, 1);
        if (!a_we) check($sformatf("rnd a read %0h", a_addr), rdata, ref_mem[a_addr]);
        else ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_be);
        a_pend = 0; a_req = 0;
      end else if (a_pend) begin
        a_age++;
        if (a_age > 40) begin
          check("rnd a timeout", a_age, 0);
          a_pend = 0; a_req = 0;
        end
      end else if (cyc < 9950 && $urandom_range(0, 2) == 0) begin
        a_addr = 11'($urandom_range(0, 15)); a_we = 1'($urandom_range(0, 1));
        a_wdata = 16'($urandom); a_be = 2'($urandom_range(0, 3));
        a_req = 1; a_pend = 1; a_age = 0;
      end
      if (b_ack) begin
        check("rnd b ack pending", {31'd0, b_pend}, 1);
        if (!b_we) check($sformatf("rnd b read %0h", b_addr), rdata, ref_mem[b_addr]);
        else ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_be);
        b_pend = 0; b_req = 0;
      end else if (b_pend) begin
        b_age++;
        if (b_age > 40) begin
          check("rnd b timeout", b_age, 0);
          b_pend = 0; b_req = 0;
        end
      end else if (cyc < 9950 && $urandom_range(0, 2) == 0) begin
        b_addr = 11'($urandom_range(0, 15)); b_we = 1'($urandom_range(0, 1));
        b_wdata = 16'($urandom); b_be = 2'($urandom_range(0, 3));
        b_req = 1; b_pend = 1; b_age = 0;
      end
    end
    check("rnd drained", {30'd0, a_pend, b_pend}, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
